// File: rtl/serial_pattern_tx_if.sv
// serial_pattern_tx_if: parallel load handshake plus the serial w stream.
// master = requester/consumer side, slave = serial_pattern_tx.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             pause;
  logic             w;
  logic             w_valid;

  modport master (
    output data_in, load_valid, pause,
    input  load_ready, w, w_valid
  );

  modport slave (
    input  data_in, load_valid, pause,
    output load_ready, w, w_valid
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: loads a WIDTH-bit word, shifts it out MSB-first on w.
// Optional run-detector model on z_expect under SERIAL_PATTERN_TX_ZMODEL_EN.
module serial_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_pattern_tx_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               Idle_state,
  output logic               Shift_state,
  output logic               Done_state
`ifdef SERIAL_PATTERN_TX_ZMODEL_EN
  ,
  output logic               z_expect
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             w_load;

  assign w_load = r_state[0] & bus.load_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (1'b1)
        r_state[0]: begin
          if (bus.load_valid) begin
            r_sr    <= bus.data_in;
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= SHIFT;
          end
        end
        r_state[1]: begin
          if (!bus.pause) begin
            if (r_cnt == '0) begin
              r_state <= DONE;
            end else begin
              r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        r_state[2]: r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

  assign Idle_state     = r_state[0];
  assign Shift_state    = r_state[1];
  assign Done_state     = r_state[2];
  assign busy           = r_state[1] | r_state[2];
  assign done           = r_state[2];
  assign bus.load_ready = r_state[0];
  // w is forced low outside SHIFT; the register keeps its last bit in DONE
  assign bus.w          = r_state[1] & r_sr[WIDTH-1];
  assign bus.w_valid    = r_state[1] & ~bus.pause;

`ifdef SERIAL_PATTERN_TX_ZMODEL_EN
  logic r_z;
  logic r_prev;
  logic r_hv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_z    <= 1'b0;
      r_prev <= 1'b0;
      r_hv   <= 1'b0;
    end else if (w_load) begin
      r_z    <= 1'b0;
      r_prev <= 1'b0;
      r_hv   <= 1'b0;
    end else if (bus.w_valid) begin
      r_z    <= r_hv & (bus.w == r_prev);
      r_prev <= bus.w;
      r_hv   <= 1'b1;
    end else if (r_state[2]) begin
      r_z    <= 1'b0;
    end
  end

  assign z_expect = r_z;
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: random frames/pauses, queue scoreboard + cycle model.
// Monitor pops expected bits on every w_valid cycle.
module tb_serial_pattern_tx;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy, done, idle_s, shift_s, done_s;
`ifdef SERIAL_PATTERN_TX_ZMODEL_EN
  logic z_expect;
`endif

  serial_pattern_tx_if #(.WIDTH(W)) bus ();

  serial_pattern_tx #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .Idle_state  (idle_s),
    .Shift_state (shift_s),
    .Done_state  (done_s)
`ifdef SERIAL_PATTERN_TX_ZMODEL_EN
    ,
    .z_expect    (z_expect)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_q[$];
  bit zq[$];

  localparam logic [7:0] V_IDLE = 8'b0010_0100;
  localparam logic [7:0] V_DONE = 8'b0101_1000;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm, string what);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %s expected none", nm, what);
  endtask

  // {shift, done_state, idle, busy, done, load_ready, w_valid, w}
  function automatic logic [7:0] vec();
    return {shift_s, done_s, idle_s, busy, done,
            bus.load_ready, bus.w_valid, bus.w};
  endfunction

  function automatic void push_frame(logic [W-1:0] wd);
    for (int j = 0; j < W; j++) begin
      exp_q.push_back(wd[W-1-j]);
      zq.push_back(j > 0 && wd[W-1-j] == wd[W-j]);
    end
  endfunction

  initial begin : monitor
    bit had_v;
    int nb;
    had_v = 1'b0;
    nb    = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        had_v = 1'b0;
        nb    = 0;
      end else begin
        chk("onehot", 32'(idle_s) + 32'(shift_s) + 32'(done_s), 1);
`ifdef SERIAL_PATTERN_TX_ZMODEL_EN
        if (had_v) begin
          if (zq.size() == 0) fail("z_expect", "z sample");
          else chk("z_expect", z_expect, zq.pop_front());
        end
        if (idle_s) chk("z_idle", z_expect, 0);
`endif
        had_v = bus.w_valid;
        if (bus.w_valid) begin
          if (exp_q.size() == 0) fail("w_bit", "extra bit");
          else chk("w_bit", bus.w, exp_q.pop_front());
          nb++;
        end
        if (done) begin
          chk("frame_len", nb, W);
          nb = 0;
        end
      end
    end
  end

  // Caller is at a negedge; checks every cycle from k+1 to first IDLE.
  task automatic frame(input logic [W-1:0] wd, input logic [31:0] pm,
                       input bit hold, input logic [W-1:0] nxt,
                       input bit poke);
    int  i, c, n;
    bit  p;
    logic [7:0] ev;
    n = 0;
    while (!bus.load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.load_ready) begin
      fail("ready_wait", "timeout");
      return;
    end
    bus.data_in    = wd;
    bus.load_valid = 1'b1;
    @(posedge clk);
    push_frame(wd);
    i = 0;
    c = 0;
    forever begin
      c++;
      #1;
      if (i < W) p = (c < 32) ? pm[c] : 1'b0;
      else p = 1'($urandom % 2);
      bus.pause = p;
      if (hold) begin
        bus.load_valid = 1'b1;
        bus.data_in    = nxt;
      end else begin
        bus.data_in    = W'($urandom);
        bus.load_valid = (poke && i <= W) ? 1'($urandom % 2) : 1'b0;
      end
      @(negedge clk);
      if (i < W) ev = {5'b10010, 1'b0, !p, wd[W-1-i]};
      else if (i == W) ev = V_DONE;
      else ev = V_IDLE;
      chk($sformatf("cycle_k+%0d", c), vec(), ev);
      if (i < W) begin
        if (!p) i++;
      end else if (i == W) begin
        i++;
      end else begin
        break;
      end
      if (c > 100) begin
        fail("frame_len_bound", "timeout");
        break;
      end
      @(posedge clk);
    end
    bus.pause = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] wd;
    reset          = 1'b0;
    bus.data_in    = '0;
    bus.load_valid = 1'b0;
    bus.pause      = 1'b0;
    #7;
    chk("reset_state", vec(), V_IDLE);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    frame(8'hB4, 32'h0, 1'b0, 8'h00, 1'b0);
    frame(8'hB4, 32'h8, 1'b0, 8'h00, 1'b0);
    frame(8'h01, 32'h0, 1'b1, 8'h80, 1'b0);
    frame(8'h80, 32'h0, 1'b0, 8'h00, 1'b0);
    frame(8'h5A, 32'h0, 1'b0, 8'h00, 1'b1);

    for (int f = 0; f < 25; f++) begin
      wd = W'($urandom);
      frame(wd, $urandom & 32'h0000_5252, 1'b0, 8'h00, 1'($urandom % 2));
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1 bus.pause = 1'($urandom % 2);
        @(negedge clk);
        chk("idle_gap", vec(), V_IDLE);
      end
      bus.pause = 1'b0;
    end

    bus.data_in    = 8'hFF;
    bus.load_valid = 1'b1;
    @(posedge clk);
    push_frame(8'hFF);
    #1 bus.load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("pre_reset_shift", shift_s, 1);
    reset = 1'b0;
    #1 chk("reset_mid", vec(), V_IDLE);
    exp_q.delete();
    zq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_idle", vec(), V_IDLE);
    end

    frame(8'hC3, 32'h24, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Transmit side of the serial `w` stream consumed by the one-hot sequence detectors.
- Accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first, one bit per `clk`, on `w` with a `w_valid` qualifier.
- Supports mid-frame pause and signals frame completion.
- Used as the stimulus/driver block feeding detector FSMs in the same design.

Parameters:
- WIDTH, 8, number of bits per frame (legal range 2..32).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- data_in  input  WIDTH  word to transmit; sampled only on load handshake.
- load_valid  input  1  requester has a word on data_in.
- load_ready  output  1  block can accept a word; high only in IDLE.
- pause  input  1  when high during SHIFT, freezes the current bit and bit counter.
- w  output  1  serial data, MSB first.
- w_valid  output  1  w carries a valid frame bit this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit of a frame.
- Idle_state, Shift_state, Done_state  output  1 each  one-hot state flags.

Behaviour:
- State register is one-hot: IDLE, SHIFT, DONE.
- Reset (reset=0, asynchronous) sets the following:
  - state=IDLE, so Idle_state=1 and Shift_state=Done_state=0.
  - Shift register=0, bit counter=0.
  - w=0, w_valid=0, busy=0, done=0, load_ready=1.
- IDLE:
  - load_ready=1, w=0, w_valid=0.
  - On a clk edge with load_valid=1: capture data_in into the shift register, set bit counter=WIDTH-1, go to SHIFT.
  - With load_valid=0: stay in IDLE.
- SHIFT:
  - w = shift register MSB; w_valid = ~pause; load_ready=0.
  - On a clk edge with pause=1: no change.
  - On a clk edge with pause=0 and counter!=0: shift the register left by 1 (zero fill) and decrement the counter.
  - On a clk edge with pause=0 and counter==0: go to DONE.
- DONE:
  - done=1, w=0, w_valid=0, load_ready=0.
  - Next edge: go to IDLE unconditionally. No back-to-back load from DONE.
- Latency, with the load accepted at edge k:
  - Bit i is on w during cycle k+1+i, for i=0..WIDTH-1, given no pauses.
  - done is high during cycle k+WIDTH+1.
  - load_ready is high again from cycle k+WIDTH+2.
  - Each paused cycle adds exactly 1 cycle to all later events.
- load_valid while load_ready=0: ignored. The requester must hold load_valid; no data is buffered.
- pause outside SHIFT: ignored.
- Changes to data_in after the handshake: no effect on the frame in flight.
- Reset mid-frame: frame aborted, block in IDLE in the same cycle, done is not pulsed.
- Exactly one state flag is high at all times after reset.

Optional Feature:
- Macro: SERIAL_PATTERN_TX_ZMODEL_EN.
- When defined:
  - Adds output `z_expect` (1 bit), reset value 0.
  - `z_expect` is a registered model of a run detector.
  - History (last valid bit, run-length-≥2 flag) is cleared on load acceptance.
  - On each w_valid cycle, if the bit equals the previous valid bit of the same frame, z_expect=1 in the following cycle; otherwise z_expect=0 in the following cycle.
  - Paused cycles hold z_expect and the history.
  - z_expect=0 in IDLE.
- When not defined: port absent, no model logic synthesised.

Test Plan:
- Reset: reset=0 mid-SHIFT of word 8'hFF -> same cycle Idle_state=1, w=0, w_valid=0, load_ready=1; no done pulse.
- WIDTH=8, load 8'hB4 at edge k, pause=0 -> w = 1,0,1,1,0,1,0,0 in cycles k+1..k+8 with w_valid=1; done=1 only in cycle k+9; load_ready=1 at k+10.
- Load 8'hB4, pause=1 during cycle k+3 only -> the bit 1 from cycle k+3 is held with w_valid=0 in k+3, then presented in k+4; done moves to k+10.
- load_valid=1 held continuously with words 8'h01 then 8'h80 -> second word accepted only at the edge ending cycle k+10; the two frames are separated by the DONE and IDLE cycles.
- load_valid pulsed while busy=1 -> ignored; frame unchanged; no second frame starts.
- ZMODEL_EN, load 8'hB4 -> z_expect=1 only in cycles k+5 and k+9; z_expect=0 elsewhere.
